// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard sequencer: forwarding selects, load-use bubbles, redirect flushes, memory freezes.
// Optional performance counters are compiled in when HAZ_PERF_EN is defined.
module ex_hazard_ctrl #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_reg,
    input  logic              d_is_load,
    input  logic              ex_redirect,
    input  logic              mem_stall,
    output logic              stall_fd,
    output logic              stall_de,
    output logic              bubble_de,
    output logic              flush_fd,
    output logic [1:0]        frwrd_sel_A,
    output logic [1:0]        frwrd_sel_B
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_LDUSE, ST_FLUSH} state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } stage_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_EM   = 2'b01;
    localparam logic [1:0] SEL_MW   = 2'b10;

    state_e     state_q;
    stage_t     e_q, m_q, e_d;
    logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d;
    logic       load_use, redirect;

    // W-stage results reach E through register-file write-through, so only E and M are kept.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src,
                                           input stage_t e, input stage_t m);
        if (!use_src)                                    return SEL_NONE;
        else if (e.valid && e.dest == src && !e.is_load) return SEL_EM;
        else if (m.valid && m.dest == src)               return SEL_MW;
        else                                             return SEL_NONE;
    endfunction

    assign load_use = d_valid && e_q.valid && e_q.is_load &&
                      ((d_use_rs && e_q.dest == d_rs) || (d_use_rt && e_q.dest == d_rt));
    assign redirect = ex_redirect && (state_q != ST_FLUSH);

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        stall_fd  = 1'b0;
        stall_de  = 1'b0;
        bubble_de = 1'b0;
        flush_fd  = 1'b0;
        if (rst) begin
            stall_fd = 1'b0;
        end else if (mem_stall) begin
            stall_fd = 1'b1;
            stall_de = 1'b1;
        end else if (redirect) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
        end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_de = 1'b1;
        end
    end

    always_comb begin
        e_d     = '0;
        sel_a_d = SEL_NONE;
        sel_b_d = SEL_NONE;
        if (!bubble_de && d_valid) begin
            e_d.valid   = d_wr_en;
            e_d.dest    = d_wr_reg;
            e_d.is_load = d_is_load;
            sel_a_d     = fwd_sel(d_use_rs, d_rs, e_q, m_q);
            sel_b_d     = fwd_sel(d_use_rt, d_rt, e_q, m_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            e_q     <= '0;
            m_q     <= '0;
            sel_a_q <= SEL_NONE;
            sel_b_q <= SEL_NONE;
        end else if (!mem_stall) begin
            m_q     <= e_q;
            e_q     <= e_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            if (redirect)      state_q <= ST_FLUSH;
            else if (load_use) state_q <= ST_LDUSE;
            else               state_q <= ST_RUN;
        end
    end

    assign frwrd_sel_A = sel_a_q;
    assign frwrd_sel_B = sel_b_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Counters keep running through memory freezes; they saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_fd && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_fd && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed scenarios then random traffic against an
// instruction-level pipeline model; a separate monitor pops expectations on the falling edge.
module tb_ex_hazard_ctrl;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              d_valid = 1'b0, d_use_rs = 1'b0, d_use_rt = 1'b0, d_wr_en = 1'b0, d_is_load = 1'b0;
    logic [REG_AW-1:0] d_rs = '0, d_rt = '0, d_wr_reg = '0;
    logic              ex_redirect = 1'b0, mem_stall = 1'b0;
    logic              stall_fd, stall_de, bubble_de, flush_fd;
    logic [1:0]        frwrd_sel_A, frwrd_sel_B;
`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    ex_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wr_en(d_wr_en), .d_wr_reg(d_wr_reg),
        .d_is_load(d_is_load), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .stall_fd(stall_fd), .stall_de(stall_de), .bubble_de(bubble_de), .flush_fd(flush_fd),
        .frwrd_sel_A(frwrd_sel_A), .frwrd_sel_B(frwrd_sel_B)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct packed {
        bit       rst, dv;
        bit [2:0] rs, rt;
        bit       urs, urt, wr;
        bit [2:0] wd;
        bit       ld, red, mem;
    } stim_t;

    typedef struct packed {
        bit        sfd, sde, bub, ffd;
        bit [1:0]  sa, sb;
        bit [15:0] sc, fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: list of in-flight instruction records, youngest first (index 0 = E, 1 = M).
    typedef struct packed {
        bit       writes;
        bit [2:0] dest;
        bit       ld;
    } ins_t;

    ins_t inflight[$];
    bit       flush_pending = 1'b0;
    bit [1:0] cur_sa = 2'b00, cur_sb = 2'b00;
    int       cnt_stall = 0, cnt_flush = 0;

    // Stage index of the youngest in-flight writer of reg, or -1.
    function automatic int producer(input bit [2:0] r);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].writes && inflight[i].dest == r) return i;
        return -1;
    endfunction

    function automatic bit [1:0] sel_for(input bit used, input bit [2:0] r);
        int p;
        if (!used) return 2'b00;
        p = producer(r);
        if (p == 0 && !inflight[0].ld) return 2'b01;
        if (p == 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit hazard(input bit used, input bit [2:0] r);
        return used && producer(r) == 0 && inflight[0].ld;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   lu;
        ins_t nw;
        @(posedge clk);
        #1;
        rst = s.rst; d_valid = s.dv; d_rs = s.rs; d_rt = s.rt; d_use_rs = s.urs; d_use_rt = s.urt;
        d_wr_en = s.wr; d_wr_reg = s.wd; d_is_load = s.ld; ex_redirect = s.red; mem_stall = s.mem;

        e = '0;
        lu = s.dv && (hazard(s.urs, s.rs) || hazard(s.urt, s.rt));
        if (!s.rst) begin
            if (s.mem)                          begin e.sfd = 1; e.sde = 1; end
            else if (s.red && !flush_pending)   begin e.ffd = 1; e.bub = 1; end
            else if (lu)                        begin e.sfd = 1; e.bub = 1; end
        end
        e.sa = cur_sa;
        e.sb = cur_sb;
        e.sc = 16'(cnt_stall);
        e.fc = 16'(cnt_flush);
        sb_q.push_back(e);

        if (s.rst) begin
            inflight.delete();
            flush_pending = 0; cur_sa = 0; cur_sb = 0; cnt_stall = 0; cnt_flush = 0;
        end else begin
            if (e.sfd && cnt_stall < 65535) cnt_stall++;
            if (e.ffd && cnt_flush < 65535) cnt_flush++;
            if (!s.mem) begin
                if (e.bub || !s.dv) begin
                    cur_sa = 0; cur_sb = 0; nw = '0;
                end else begin
                    cur_sa = sel_for(s.urs, s.rs);
                    cur_sb = sel_for(s.urt, s.rt);
                    nw = '{writes: s.wr, dest: s.wd, ld: s.ld};
                end
                inflight.push_front(nw);
                while (inflight.size() > 2) void'(inflight.pop_back());
                flush_pending = e.ffd;
            end
        end
    endtask

    function automatic stim_t op(input bit dv, input bit wr, input bit [2:0] wd, input bit ld,
                                 input bit urs, input bit [2:0] rs, input bit urt, input bit [2:0] rt);
        stim_t s = '0;
        s.dv = dv; s.wr = wr; s.wd = wd; s.ld = ld; s.urs = urs; s.rs = rs; s.urt = urt; s.rt = rt;
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("stall_fd",  32'(stall_fd),    32'(e.sfd));
            check("stall_de",  32'(stall_de),    32'(e.sde));
            check("bubble_de", 32'(bubble_de),   32'(e.bub));
            check("flush_fd",  32'(flush_fd),    32'(e.ffd));
            check("sel_A",     32'(frwrd_sel_A), 32'(e.sa));
            check("sel_B",     32'(frwrd_sel_B), 32'(e.sb));
`ifdef HAZ_PERF_EN
            check("stall_cnt", 32'(stall_cnt),   32'(e.sc));
            check("flush_cnt", 32'(flush_cnt),   32'(e.fc));
`endif
        end
    end

    initial begin
        stim_t s, idle, rs_only;
        int    budget;
        idle = '0;
        s = idle; s.rst = 1;
        step(s); step(s);
        // ADD R1 then SUB reading R1 as rs -> sel_A 01
        step(op(1, 1, 3'd1, 0, 1, 3'd6, 1, 3'd7));
        step(op(1, 1, 3'd2, 0, 1, 3'd1, 1, 3'd6));
        step(idle); step(idle);
        // R2 producer, gap, rt consumer -> sel_B 10; then distance 3 -> 00
        step(op(1, 1, 3'd2, 0, 0, 3'd0, 0, 3'd0));
        step(op(0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0));
        step(op(1, 0, 3'd0, 0, 0, 3'd0, 1, 3'd2));
        step(op(1, 1, 3'd3, 0, 0, 3'd0, 0, 3'd0));
        step(op(0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0));
        step(op(0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0));
        step(op(1, 0, 3'd0, 0, 0, 3'd0, 1, 3'd3));
        step(idle);
        // LD R3 then ADD R4,R3,R5: one bubble, then sel_A 10
        step(op(1, 1, 3'd3, 1, 0, 3'd0, 0, 3'd0));
        step(op(1, 1, 3'd4, 0, 1, 3'd3, 1, 3'd5));
        step(op(1, 1, 3'd4, 0, 1, 3'd3, 1, 3'd5));
        step(idle);
        // Single-cycle redirect, then a redirect held into the flush cycle
        s = idle; s.red = 1;
        step(s); step(idle); step(s); step(s); step(idle);
        // Load-use with mem_stall held three cycles
        step(op(1, 1, 3'd0, 1, 0, 3'd0, 0, 3'd0));
        rs_only = op(1, 1, 3'd5, 0, 1, 3'd0, 0, 3'd0);
        s = rs_only; s.mem = 1;
        step(s); step(s); step(s);
        step(rs_only); step(rs_only); step(idle);
        // Redirect coinciding with load-use
        step(op(1, 1, 3'd6, 1, 0, 3'd0, 0, 3'd0));
        s = op(1, 1, 3'd1, 0, 0, 3'd0, 1, 3'd6); s.red = 1;
        step(s); step(idle);
        // Reset while in LDUSE
        step(op(1, 1, 3'd3, 1, 0, 3'd0, 0, 3'd0));
        rs_only = op(1, 1, 3'd4, 0, 1, 3'd3, 0, 3'd0);
        step(rs_only);
        s = rs_only; s.rst = 1;
        step(s); step(rs_only); step(idle);

        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst = ($urandom_range(0, 79) == 0);
            s.mem = ($urandom_range(0, 5) == 0);
            s.red = ($urandom_range(0, 9) == 0);
            s.dv  = ($urandom_range(0, 4) != 0);
            s.urs = $urandom_range(0, 1);
            s.urt = $urandom_range(0, 1);
            s.wr  = ($urandom_range(0, 3) != 0);
            s.ld  = ($urandom_range(0, 2) == 0);
            s.rs  = 3'($urandom_range(0, 3));
            s.rt  = 3'($urandom_range(0, 3));
            s.wd  = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s.rs = 3'($urandom_range(0, 7));
            step(s);
        end
        step(idle);

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
